digit_serial_adder: RTL and testbench
=====================================

// Module: digit_serial_adder
//
// PURPOSE
// Multi-cycle N-bit adder that feeds a 2-bit adder slice with successive 2-bit digits of two latched operands.
// Each cycle it captures the slice's 2-bit sum and carry-out, and chains the carry into the next digit.
// Sits upstream of the 2-bit adder slice and drives its operand inputs.
// Trades latency for area: one 2-bit slice serves any even operand width.
//
// PARAMETERS
// WIDTH   8   operand/result width in bits; must be even and >= 2
//
// PORTS
// clock   in   1       rising-edge clock
// reset   in   1       synchronous, active-high reset
// start   in   1       request; sampled only in IDLE or DONE
// A       in   WIDTH   operand A, latched on accepted start
// B       in   WIDTH   operand B, latched on accepted start
// busy    out  1       high while in RUN
// done    out  1       one-cycle pulse when S/Cout become valid
// S       out  WIDTH   sum; held from done until the next accepted start
// Cout    out  1       final carry-out; held like S
//
// BEHAVIOUR
// - Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
// - Reset effect: state=IDLE; busy=0, done=0, S=0, Cout=0; internal carry=0, digit counter=0.
// - Reset mid-RUN aborts the operation. There is no partial result, and done is not pulsed.
// - FSM states (encoding in package): IDLE, RUN, DONE.
// - IDLE/DONE + start=1: latch A, B into shift registers, clear carry, counter=0, clear S, go to RUN.
// - RUN, each edge:
//   * slice adds opA[1:0] + opB[1:0] + carry.
//   * 2-bit sum shifts into S from the MSB end; carry <= slice carry.
//   * opA and opB shift right by 2; counter++.
// - RUN -> DONE on the edge that processes digit WIDTH/2-1. On that edge, Cout <= final carry.
// - DONE: done=1 for exactly one cycle.
//   * next state is RUN if start=1 (back-to-back accepted), else IDLE.
// - Latency: start sampled at edge E0.
//   * busy=1 during cycles E0..E0+WIDTH/2.
//   * done=1 during the cycle after edge E0+WIDTH/2; for WIDTH=8, done is high 5 cycles after start.
// - start during RUN is ignored. A/B changes after acceptance have no effect.
// - Arithmetic: {Cout,S} = A + B, unsigned, modulo 2^(WIDTH+1). All-ones + 1 wraps: S=0, Cout=1.
// - S is not valid while busy=1: partially shifted digits are visible and must not be sampled.
//
// CONFIGURATION
// - Macro DIGIT_SERIAL_ADDER_OVF_EN.
// - Defined:
//   * adds port `Ovf out 1`: two's-complement signed overflow, carry into MSB XOR carry out of MSB.
//   * Ovf is computed on the last digit and updated/held/reset exactly like Cout.
// - Undefined: no Ovf port, no overflow logic; everything else is identical.
//
// STRUCTURE
// - Shared package digit_serial_adder_pkg.vh holds:
//   * state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//   * localparam DIGITS = WIDTH/2 and the counter-width expression.
// - One sub-module, add2_slice: combinational 2-bit adder with carry-in.
//   * ports a[1:0], b[1:0], cin, s[1:0], cout.
//   * instantiated once. FSM, shift registers and counter stay in the top.
//
// TESTING
// (WIDTH=8; check done timing and held outputs in every case)
// 1. Reset, then 8'h00+8'h00 -> done exactly 5 cycles after start; S=8'h00, Cout=0; busy high for cycles 0-4.
// 2. 8'hFF+8'h01 -> S=8'h00, Cout=1 (full carry ripple across all 4 digits).
// 3. 8'h5A+8'h3C -> S=8'h96, Cout=0. Then drive start=1 with new A/B in cycle 2 of RUN -> ignored, result unchanged.
// 4. Start 8'hC8+8'h64; assert reset in cycle 2 of RUN -> next cycle busy=0, S=0, Cout=0, state IDLE; no done pulse.
// 5. Back-to-back: start held during the DONE cycle with 8'h80+8'h80 -> second op accepted; S=8'h00, Cout=1 five cycles later.
// 6. With DIGIT_SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> S=8'h80, Cout=0, Ovf=1; 8'hFF+8'h01 -> Ovf=0.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// digit/counter sizing helpers.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned digits_of(input int unsigned width);
    return width / 2;
  endfunction

  // A single-digit adder still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_add2_slice.sv
// Combinational 2-bit adder slice with carry-in; one digit of the serial adder.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [2:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {2'b00, cin};
  assign s    = sum[1:0];
  assign cout = sum[2];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: one 2-bit slice processes the operands LSB digit first.
// Optional signed-overflow output enabled by macro DIGIT_SERIAL_ADDER_OVF_EN.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned DIGITS = digits_of(WIDTH);
  localparam int unsigned CW     = cnt_width(DIGITS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             load, step, last;
  logic [1:0]       slice_s;
  logic             slice_cout;
  logic [WIDTH+1:0] s_shift;

  add2_slice u_slice (
    .a    (opa_q[1:0]),
    .b    (opb_q[1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // New digit enters at the MSB end; written this way so WIDTH=2 needs no special case.
  assign s_shift = {slice_s, S};

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
      Ovf     <= 1'b0;
`endif
    end else if (load) begin
      opa_q   <= A;
      opb_q   <= B;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
    end else if (step) begin
      S       <= s_shift[WIDTH+1:2];
      carry_q <= slice_cout;
      opa_q   <= opa_q >> 2;
      opb_q   <= opb_q >> 2;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        Cout <= slice_cout;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        // Carry into the MSB is recovered from the MSB sum bit, so the slice stays 2-bit.
        Ovf  <= (opa_q[1] ^ opb_q[1] ^ slice_s[1]) ^ slice_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder (WIDTH=8): table-driven vectors plus
// hand-written multi-cycle sequences, checked through an expected-result queue.
module tb_digit_serial_adder;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done, Cout;
  logic [W-1:0] S;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
  logic         Ovf;
`endif

  digit_serial_adder #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int unsigned  due;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected done: S=%0h Cout=%0b with no operation pending", S, Cout);
      end else begin
        mon_e = sb.pop_front();
        chk("S at done", 32'(S), 32'(mon_e.s));
        chk("Cout at done", 32'(Cout), 32'(mon_e.c));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        chk("Ovf at done", 32'(Ovf), 32'(mon_e.o));
`endif
        chk("done cycle", cyc, mon_e.due);
      end
    end
  end

  // Called at a negedge: drives an accepted start on the next rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit push);
    A     = a;
    B     = b;
    start = 1'b1;
    if (push) sb.push_back('{s: es, c: ec, o: eo, due: cyc + 5});
  endtask

  // Runs the op to done, checking busy each RUN cycle and the held result afterwards.
  // inject drives a fresh start with different operands in RUN cycle 2.
  task automatic finish_op(input logic [W-1:0] es, input logic ec, input logic eo,
                           input bit inject);
    int k;
    @(negedge clock);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    k     = 0;
    while (done !== 1'b1 && k < 12) begin
      chk("busy in RUN", 32'(busy), 32'(1));
      k++;
      if (inject && k == 1) begin
        start = 1'b1;
        A     = 8'hFF;
        B     = 8'hFF;
      end else if (inject && k == 2) begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done timeout: no done within 12 cycles");
    end else begin
      chk("busy at done", 32'(busy), 32'(0));
    end
    @(negedge clock);
    chk("done one cycle", 32'(done), 32'(0));
    chk("busy after done", 32'(busy), 32'(0));
    chk("S held", 32'(S), 32'(es));
    chk("Cout held", 32'(Cout), 32'(ec));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk("Ovf held", 32'(Ovf), 32'(eo));
`endif
  endtask

  vec_t vecs[8];

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         ro;

    vecs[0] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0, o: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1, o: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0, o: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0, o: 1'b0};
    vecs[4] = '{a: 8'h12, b: 8'h34, s: 8'h46, c: 1'b0, o: 1'b0};
    vecs[5] = '{a: 8'hAA, b: 8'hAA, s: 8'h54, c: 1'b1, o: 1'b1};
    vecs[6] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1, o: 1'b1};
    vecs[7] = '{a: 8'hC8, b: 8'h64, s: 8'h2C, c: 1'b1, o: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clock);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset S", 32'(S), 32'(0));
    chk("reset Cout", 32'(Cout), 32'(0));
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    chk("reset Ovf", 32'(Ovf), 32'(0));
`endif
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].o, 1'b1);
      finish_op(vecs[i].s, vecs[i].c, vecs[i].o, 1'b0);
      @(negedge clock);
    end

    // start during RUN with different operands must be ignored
    start_op(8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 1'b1);
    finish_op(8'h96, 1'b0, 1'b0, 1'b1);
    @(negedge clock);

    // leave Cout=1 so the mid-RUN reset has something to clear
    start_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    finish_op(8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    start_op(8'hC8, 8'h64, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort S", 32'(S), 32'(0));
    chk("abort Cout", 32'(Cout), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("no done after abort", 32'(done), 32'(0));
    end

    // back-to-back: start held during the DONE cycle
    start_op(8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 12 && done !== 1'b1; k++) @(negedge clock);
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL back-to-back first done timeout");
    end
    start_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1);
    finish_op(8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      full = {1'b0, ra} + {1'b0, rb};
      ro   = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      start_op(ra, rb, full[W-1:0], full[W], ro, 1'b1);
      finish_op(full[W-1:0], full[W], ro, 1'b0);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
